bm_pipe_mux_tree: RTL

- Parametrised, pipelined N:1 multiplexer built as a radix-4 tree, with one register stage per tree level.
- Successor to the combinational 16:1 microbenchmark. Generalised in lane count and lane width.
- Adds valid/ready flow control with global stall, so it can sit between streaming producers and consumers in the benchmark suite.

---
 rtl/bm_pipe_mux_pkg.sv | 31 +++
 rtl/mux4_stage.sv | 57 +++++
 rtl/bm_pipe_mux_tree.sv | 103 ++++++++++
 3 files changed

// File: rtl/bm_pipe_mux_pkg.sv
// Shared helpers for the pipelined radix-4 mux tree: tree-depth calculation
// and lane-count legality check.
package bm_pipe_mux_pkg;

    // Each tree level consumes two select bits (one radix-4 digit).
    localparam int SEL_W_PER_LVL = 2;

    // Number of radix-4 levels needed to cover n lanes.
    function automatic int clog4(input int n);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < n) begin
            span = span * 4;
            lvl  = lvl + 1;
        end
        return lvl;
    endfunction

    // Lane count must be an exact power of 4, at least 4.
    function automatic bit num_in_legal(input int n);
        int span;
        span = 4;
        while (span < n) begin
            span = span * 4;
        end
        return (n >= 4) && (span == n);
    endfunction

endpackage

// File: rtl/mux4_stage.sv
// One registered radix-4 level of the mux tree. GROUPS independent 4:1 muxes
// share the same two-bit select digit taken from position LVL of the full
// select word; the full select word travels along so the output can report it.
module mux4_stage
    import bm_pipe_mux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int GROUPS = 1,
    parameter int SEL_W  = 2,
    parameter int LVL    = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       vld_in,
    input  logic [GROUPS*4*DATA_W-1:0] d_in,
    input  logic [SEL_W-1:0]           sel_in,
    output logic                       vld_p,
    output logic [GROUPS*DATA_W-1:0]   d_p,
    output logic [SEL_W-1:0]           sel_p
);

    logic [SEL_W_PER_LVL-1:0]   digit;
    logic [GROUPS*DATA_W-1:0]   d_nxt;

    assign digit = sel_in[LVL*SEL_W_PER_LVL +: SEL_W_PER_LVL];

    // Pick one of four inputs in every group using this level's select digit.
    always_comb begin
        d_nxt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            d_nxt[g*DATA_W +: DATA_W] = d_in[(g*4 + int'(digit))*DATA_W +: DATA_W];
        end
    end

    // ---- stage register boundary ----
    // Valid bit follows upstream whenever the pipeline advances (bubbles included).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= 1'b0;
        end else if (en) begin
            vld_p <= vld_in;
        end
    end

    // Data and select only load real items, so a bubble never clobbers held data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_p   <= '0;
            sel_p <= '0;
        end else if (en && vld_in) begin
            d_p   <= d_nxt;
            sel_p <= sel_in;
        end
    end

endmodule

// File: rtl/bm_pipe_mux_tree.sv
// Pipelined NUM_IN:1 mux built as a radix-4 tree, one register per level,
// with valid/ready flow control and a single global stall.
// Optional feature: define BM_PIPE_MUX_PARITY_EN to add output f_par, the
// XOR-reduction of the selected lane, carried through the tree with the data.
module bm_pipe_mux_tree
    import bm_pipe_mux_pkg::*;
#(
    parameter  int DATA_W = 1,
    parameter  int NUM_IN = 16,
    localparam int LEVELS = clog4(NUM_IN)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_IN*DATA_W-1:0]   W,
    input  logic [2*LEVELS-1:0]        S,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          f,
    output logic [2*LEVELS-1:0]        sel_out
`ifdef BM_PIPE_MUX_PARITY_EN
    ,
    output logic                       f_par
`endif
);

    localparam int SEL_W = SEL_W_PER_LVL * LEVELS;
`ifdef BM_PIPE_MUX_PARITY_EN
    localparam int LANE_W = DATA_W + 1;
`else
    localparam int LANE_W = DATA_W;
`endif

    if (!num_in_legal(NUM_IN)) begin : g_bad_num_in
        $error("bm_pipe_mux_tree: NUM_IN must be a power of 4 and at least 4");
    end

    logic                       en;
    logic [NUM_IN*LANE_W-1:0]   lanes;

    // The whole pipeline advances unless a valid result is waiting on downstream.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

`ifdef BM_PIPE_MUX_PARITY_EN
    // Widen each lane with its parity bit so the tree carries it alongside the data.
    always_comb begin
        lanes = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            lanes[i*LANE_W +: LANE_W] = {^W[i*DATA_W +: DATA_W], W[i*DATA_W +: DATA_W]};
        end
    end
`else
    assign lanes = W;
`endif

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int GROUPS = NUM_IN >> (2 * (k + 1));

        logic                       vld_in;
        logic [GROUPS*4*LANE_W-1:0] d_in;
        logic [SEL_W-1:0]           sel_in;
        logic                       vld_p;
        logic [GROUPS*LANE_W-1:0]   d_p;
        logic [SEL_W-1:0]           sel_p;

        if (k == 0) begin : g_src
            assign vld_in = in_valid;
            assign d_in   = lanes;
            assign sel_in = S;
        end else begin : g_chain
            assign vld_in = g_lvl[k-1].vld_p;
            assign d_in   = g_lvl[k-1].d_p;
            assign sel_in = g_lvl[k-1].sel_p;
        end

        mux4_stage #(
            .DATA_W (LANE_W),
            .GROUPS (GROUPS),
            .SEL_W  (SEL_W),
            .LVL    (k)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (en),
            .vld_in  (vld_in),
            .d_in    (d_in),
            .sel_in  (sel_in),
            .vld_p   (vld_p),
            .d_p     (d_p),
            .sel_p   (sel_p)
        );
    end

    assign out_valid = g_lvl[LEVELS-1].vld_p;
    assign f         = g_lvl[LEVELS-1].d_p[DATA_W-1:0];
    assign sel_out   = g_lvl[LEVELS-1].sel_p;
`ifdef BM_PIPE_MUX_PARITY_EN
    assign f_par     = g_lvl[LEVELS-1].d_p[DATA_W];
`endif

endmodule
